// File: rtl/reg_wr_arbiter_if.sv
// Write-port bundle between the two writeback requesters, the arbiter and the register file.
interface reg_wr_arbiter_if #(
  parameter int PW = 4,
  parameter int DW = 8
);
  logic          req0;
  logic [PW-1:0] wr0_addr;
  logic [DW-1:0] wr0_dat;
  logic          swap0;
  logic [PW-1:0] swp_addr;
  logic [DW-1:0] swp_dat;
  logic          gnt0;
  logic          req1;
  logic [PW-1:0] wr1_addr;
  logic [DW-1:0] wr1_dat;
  logic          gnt1;
  logic          rf_wr_en;
  logic [PW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_dat_in;
  logic          busy;
  logic [7:0]    conflicts;

  modport master (
    output req0, wr0_addr, wr0_dat, swap0, swp_addr, swp_dat,
    output req1, wr1_addr, wr1_dat,
    input  gnt0, gnt1, rf_wr_en, rf_wr_addr, rf_dat_in, busy, conflicts
  );

  modport slave (
    input  req0, wr0_addr, wr0_dat, swap0, swp_addr, swp_dat,
    input  req1, wr1_addr, wr1_dat,
    output gnt0, gnt1, rf_wr_en, rf_wr_addr, rf_dat_in, busy, conflicts
  );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port; grants are same-cycle (zero latency).
// Losers and any request during the second swap write are back-pressured by holding gnt low.
module reg_wr_arbiter #(
  parameter int PW = 4,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             reset,
  reg_wr_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWAP2 = 1'b1;

  logic [0:0]    state_q;
  logic          prio_q;
  logic [PW-1:0] swp_addr_q;
  logic [DW-1:0] swp_dat_q;
  logic [7:0]    conf_q;

  logic          gnt0;
  logic          gnt1;
  logic          wr_en;
  logic          busy;
  logic [PW-1:0] wr_addr;
  logic [DW-1:0] wr_dat;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b0;
    wr_addr = '0;
    wr_dat  = '0;
    if (!reset) begin
      if (state_q == SWAP2) begin
        wr_en   = 1'b1;
        wr_addr = swp_addr_q;
        wr_dat  = swp_dat_q;
        busy    = 1'b1;
      end else if (bus.req0 && (!bus.req1 || !prio_q)) begin
        gnt0    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = bus.wr0_addr;
        wr_dat  = bus.wr0_dat;
      end else if (bus.req1) begin
        gnt1    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = bus.wr1_addr;
        wr_dat  = bus.wr1_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      swp_addr_q <= '0;
      swp_dat_q  <= '0;
      conf_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Priority always moves to whichever requester did not win.
          if (gnt0) begin
            prio_q <= 1'b1;
          end else if (gnt1) begin
            prio_q <= 1'b0;
          end
          if (gnt0 && bus.swap0) begin
            swp_addr_q <= bus.swp_addr;
            swp_dat_q  <= bus.swp_dat;
            state_q    <= SWAP2;
          end
          if (bus.req0 && bus.req1 && (conf_q != 8'hFF)) begin
            conf_q <= conf_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.rf_wr_en   = wr_en;
  assign bus.rf_wr_addr = wr_addr;
  assign bus.rf_dat_in  = wr_dat;
  assign bus.busy       = busy;
  assign bus.conflicts  = conf_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed vector table plus randomized requesters checked against a queue-based reference model.
module tb_reg_wr_arbiter;
  localparam int PW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_wr_arbiter_if #(.PW(PW), .DW(DW)) bus ();
  reg_wr_arbiter #(.PW(PW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Register file image built from what the DUT actually writes.
  logic [DW-1:0] rf_dut [16];
  always @(posedge clk) if (bus.rf_wr_en) rf_dut[bus.rf_wr_addr] <= bus.rf_dat_in;

  typedef struct {
    int rst, r0, a0, d0, s0, sa, sd, r1, a1, d1;
    int g0, g1, we, ea, ed, eb, ec;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: priority holder, pending second-writes, conflict count, register contents.
  int m_prio = 0;
  int m_conf = 0;
  int m_w;
  int m_pend_a[$];
  int m_pend_d[$];
  int m_rf [16];
  bit m_wr [16];
  int e_g0, e_g1, e_we, e_ea, e_ed, e_eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int rst, int r0, int a0, int d0, int s0, int sa, int sd,
                              int r1, int a1, int d1, int g0, int g1, int we,
                              int ea, int ed, int eb, int ec);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.s0 = s0; v.sa = sa; v.sd = sd;
    v.r1 = r1; v.a1 = a1; v.d1 = d1; v.g0 = g0; v.g1 = g1; v.we = we;
    v.ea = ea; v.ed = ed; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic run_cycle(input bit use_tbl, input vec_t v, input string tag);
    reset         = 1'(v.rst);
    bus.req0      = 1'(v.r0);
    bus.wr0_addr  = PW'(v.a0);
    bus.wr0_dat   = DW'(v.d0);
    bus.swap0     = 1'(v.s0);
    bus.swp_addr  = PW'(v.sa);
    bus.swp_dat   = DW'(v.sd);
    bus.req1      = 1'(v.r1);
    bus.wr1_addr  = PW'(v.a1);
    bus.wr1_dat   = DW'(v.d1);
    #2;
    // Expected outputs from the model's view of this cycle.
    m_w = -1;
    e_g0 = 0; e_g1 = 0; e_we = 0; e_ea = 0; e_ed = 0; e_eb = 0;
    if (v.rst == 0) begin
      if (m_pend_a.size() > 0) begin
        e_we = 1; e_eb = 1; e_ea = m_pend_a[0]; e_ed = m_pend_d[0];
      end else begin
        if (v.r0 != 0 && v.r1 != 0) m_w = m_prio;
        else if (v.r0 != 0)         m_w = 0;
        else if (v.r1 != 0)         m_w = 1;
        if (m_w == 0) begin e_g0 = 1; e_we = 1; e_ea = v.a0; e_ed = v.d0; end
        if (m_w == 1) begin e_g1 = 1; e_we = 1; e_ea = v.a1; e_ed = v.d1; end
      end
    end
    if (use_tbl) begin
      chk({tag, ".gnt0"}, 32'(bus.gnt0), v.g0);
      chk({tag, ".gnt1"}, 32'(bus.gnt1), v.g1);
      chk({tag, ".wr_en"}, 32'(bus.rf_wr_en), v.we);
      chk({tag, ".busy"}, 32'(bus.busy), v.eb);
      if (v.rst == 0) begin
        chk({tag, ".addr"}, 32'(bus.rf_wr_addr), v.ea);
        chk({tag, ".dat"}, 32'(bus.rf_dat_in), v.ed);
      end
      if (v.ec >= 0) chk({tag, ".conflicts"}, 32'(bus.conflicts), v.ec);
    end else begin
      chk({tag, ".gnt0"}, 32'(bus.gnt0), e_g0);
      chk({tag, ".gnt1"}, 32'(bus.gnt1), e_g1);
      chk({tag, ".wr_en"}, 32'(bus.rf_wr_en), e_we);
      chk({tag, ".busy"}, 32'(bus.busy), e_eb);
      if (v.rst == 0) begin
        chk({tag, ".addr"}, 32'(bus.rf_wr_addr), e_ea);
        chk({tag, ".dat"}, 32'(bus.rf_dat_in), e_ed);
      end
      chk({tag, ".conflicts"}, 32'(bus.conflicts), m_conf);
    end
    @(posedge clk);
    if (v.rst != 0) begin
      m_prio = 0; m_conf = 0;
      m_pend_a.delete(); m_pend_d.delete();
    end else if (m_pend_a.size() > 0) begin
      m_rf[m_pend_a[0]] = m_pend_d[0]; m_wr[m_pend_a[0]] = 1'b1;
      void'(m_pend_a.pop_front()); void'(m_pend_d.pop_front());
    end else begin
      if (m_w >= 0) begin
        m_rf[e_ea] = e_ed; m_wr[e_ea] = 1'b1;
        m_prio = 1 - m_w;
      end
      if (m_w == 0 && v.s0 != 0) begin
        m_pend_a.push_back(v.sa); m_pend_d.push_back(v.sd);
      end
      if (v.r0 != 0 && v.r1 != 0 && m_conf < 255) m_conf++;
    end
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  bit h_r0, h_r1;
  int h_a0, h_d0, h_s0, h_sa, h_sd, h_a1, h_d1;

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.wr0_addr = '0; bus.wr0_dat = '0; bus.swap0 = 1'b0;
    bus.swp_addr = '0; bus.swp_dat = '0; bus.req1 = 1'b0; bus.wr1_addr = '0; bus.wr1_dat = '0;

    //              rst r0 a0 d0    s0 sa  sd    r1 a1 d1    g0 g1 we ea ed    eb ec
    tbl.push_back(mk(1, 1, 0, 'h00, 0, 0, 'h00, 1, 0, 'h00, 0, 0, 0, 0, 'h00, 0, -1));
    tbl.push_back(mk(1, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 1, 3, 'h5A, 0, 0, 'h00, 0, 0, 'h00, 1, 0, 1, 3, 'h5A, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 1, 9, 'h33, 0, 1, 1, 9, 'h33, 0, 0));
    tbl.push_back(mk(1, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 'h10, 0, 0, 'h00, 1, 2, 'h20, 1, 0, 1, 1, 'h10, 0, 0));
    tbl.push_back(mk(0, 1, 1, 'h10, 0, 0, 'h00, 1, 2, 'h20, 0, 1, 1, 2, 'h20, 0, 1));
    tbl.push_back(mk(0, 1, 1, 'h10, 0, 0, 'h00, 1, 2, 'h20, 1, 0, 1, 1, 'h10, 0, 2));
    tbl.push_back(mk(0, 1, 1, 'h10, 0, 0, 'h00, 1, 2, 'h20, 0, 1, 1, 2, 'h20, 0, 3));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 4));
    tbl.push_back(mk(0, 1, 2, 'h11, 1, 7, 'h22, 0, 0, 'h00, 1, 0, 1, 2, 'h11, 0, 4));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 1, 4, 'h44, 0, 0, 1, 7, 'h22, 1, 4));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 1, 4, 'h44, 0, 1, 1, 4, 'h44, 0, 4));
    tbl.push_back(mk(0, 1, 5, 'h0F, 1, 5, 'hF0, 1, 6, 'h66, 1, 0, 1, 5, 'h0F, 0, 4));
    tbl.push_back(mk(0, 1, 5, 'h0F, 1, 5, 'hF0, 1, 6, 'h66, 0, 0, 1, 5, 'hF0, 1, 5));
    tbl.push_back(mk(0, 1, 5, 'h0F, 1, 5, 'hF0, 1, 6, 'h66, 0, 1, 1, 6, 'h66, 0, 5));
    tbl.push_back(mk(0, 1, 8, 'h81, 1, 9, 'h92, 0, 0, 'h00, 1, 0, 1, 8, 'h81, 0, 6));
    tbl.push_back(mk(1, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 6));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 1, 1, 'h77, 0, 1, 1, 1, 'h77, 0, 0));
    tbl.push_back(mk(0, 1, 2, 'h12, 0, 0, 'h00, 0, 0, 'h00, 1, 0, 1, 2, 'h12, 0, 0));
    tbl.push_back(mk(0, 1, 2, 'h12, 1, 14, 'hEE, 1, 3, 'h31, 0, 1, 1, 3, 'h31, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 1));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) run_cycle(1'b1, tbl[i], $sformatf("vec%0d", i));

    chk("same_addr_swap.reg5", 32'(rf_dut[5]), 32'h0000_00F0);
    chk("reset_in_swap2.reg9", 32'(rf_dut[9]), 32'h0000_0033);

    // Saturation: both requesters held well past 255 conflict cycles.
    run_cycle(1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat_rst");
    for (int i = 0; i < 300; i++)
      run_cycle(1'b0, mk(0, 1, i % 16, i % 256, 0, 0, 0, 1, (i + 3) % 16, (i * 7) % 256,
                         0, 0, 0, 0, 0, 0, 0), "sat");
    chk("sat.conflicts_final", 32'(bus.conflicts), 32'd255);

    // Randomized requesters that hold their payload until granted.
    h_r0 = 1'b0; h_r1 = 1'b0;
    h_a0 = 0; h_d0 = 0; h_s0 = 0; h_sa = 0; h_sd = 0; h_a1 = 0; h_d1 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!h_r0 && $urandom_range(2) != 0) begin
        h_r0 = 1'b1;
        h_a0 = int'($urandom_range(15)); h_d0 = int'($urandom_range(255));
        h_s0 = ($urandom_range(2) == 0) ? 1 : 0;
        h_sa = int'($urandom_range(15)); h_sd = int'($urandom_range(255));
      end
      if (!h_r1 && $urandom_range(2) != 0) begin
        h_r1 = 1'b1;
        h_a1 = int'($urandom_range(15)); h_d1 = int'($urandom_range(255));
      end
      v = mk(($urandom_range(60) == 0) ? 1 : 0, int'(h_r0), h_a0, h_d0, h_s0, h_sa, h_sd,
             int'(h_r1), h_a1, h_d1, 0, 0, 0, 0, 0, 0, 0);
      run_cycle(1'b0, v, "rnd");
      if (m_w == 0) h_r0 = 1'b0;
      if (m_w == 1) h_r1 = 1'b0;
    end

    for (int i = 0; i < 16; i++)
      if (m_wr[i]) chk($sformatf("rf_final[%0d]", i), 32'(rf_dut[i]), m_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
